// File: rtl/mem_byte_sequencer.sv
// Arbitrates the fetch and load/store ports onto a byte-wide, fixed-latency RAM, splitting each access
// into little-endian single-byte transactions. Optional misaligned data-access trap: MEM_SEQ_MISALIGN_TRAP_EN.
module mem_byte_sequencer #(
    parameter int FLUSH_CYCLES = 4,
    parameter bit ROUND_ROBIN  = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_if_req,
    input  logic [31:0] i_if_address,
    output logic [31:0] o_if_data,
    output logic        o_if_ack,
    input  logic        i_d_req,
    input  logic        i_d_write,
    input  logic [1:0]  i_d_size,
    input  logic [31:0] i_d_address,
    input  logic [31:0] i_d_wdata,
    output logic [31:0] o_d_rdata,
    output logic        o_d_ack,
    output logic        o_d_misalign,
    output logic [31:0] o_mem_address,
    output logic [7:0]  o_mem_data,
    output logic        o_mem_write,
    output logic        o_mem_request,
    input  logic [7:0]  i_mem_data,
    input  logic        i_mem_data_DV
);
    localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic [1:0] {FLUSH, IDLE, ACCESS, GAP} state_t;

    state_t        state, state_next;
    logic [CW-1:0] flush_cnt;
    logic [31:0]   base, wdata, result, result_cap;
    logic [1:0]    k, last_k, grant_last_k;
    logic          wr, grant_d, last_data;
    logic          if_pend, d_pend, pick_d, grant, trap_hit, done;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) state <= FLUSH;
        else         state <= state_next;
    end

    // NOTE: every signal gets a default first; a path that skips an assignment would infer a latch.
    always_comb begin
        state_next    = state;
        o_mem_request = 1'b0;
        o_mem_write   = 1'b0;
        o_mem_address = '0;
        o_mem_data    = '0;
        result_cap    = result;
        done          = 1'b0;
        // A port is masked during its own ack cycle, so a held req only counts again one cycle later.
        if_pend = i_if_req & ~o_if_ack;
        d_pend  = i_d_req & ~o_d_ack;
        if (if_pend && d_pend) pick_d = ROUND_ROBIN ? ~last_data : 1'b1;
        else                   pick_d = d_pend;
        grant = (state == IDLE) && (if_pend || d_pend);
        if (!pick_d)                grant_last_k = 2'd3;
        else if (i_d_size == 2'b00) grant_last_k = 2'd0;
        else if (i_d_size == 2'b01) grant_last_k = 2'd1;
        else                        grant_last_k = 2'd3;
`ifdef MEM_SEQ_MISALIGN_TRAP_EN
        trap_hit = grant && pick_d &&
                   ((i_d_size == 2'b01 && i_d_address[0]) ||
                    (i_d_size[1] && i_d_address[1:0] != 2'b00));
`else
        trap_hit = 1'b0;
`endif
        case (state)
            FLUSH:   if (flush_cnt == '0) state_next = IDLE;
            IDLE:    if (grant && !trap_hit) state_next = ACCESS;
            ACCESS: begin
                o_mem_request = 1'b1;
                o_mem_write   = wr;
                o_mem_address = base + {30'd0, k};
                o_mem_data    = wdata[{k, 3'b000} +: 8];
                if (!wr) result_cap[{k, 3'b000} +: 8] = i_mem_data;
                if (i_mem_data_DV) begin
                    done       = (k == last_k);
                    state_next = done ? IDLE : GAP;
                end
            end
            GAP:     state_next = ACCESS;
            default: state_next = FLUSH;
        endcase
    end

    // NOTE: non-blocking assignments so every register updates from the values seen before the edge.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            flush_cnt <= CW'(FLUSH_CYCLES - 1);
            base      <= '0;
            wdata     <= '0;
            result    <= '0;
            k         <= '0;
            last_k    <= '0;
            wr        <= 1'b0;
            grant_d   <= 1'b0;
            last_data <= 1'b1;
            o_if_data <= '0;
            o_if_ack  <= 1'b0;
            o_d_rdata <= '0;
            o_d_ack   <= 1'b0;
        end else begin
            o_if_ack <= 1'b0;
            o_d_ack  <= 1'b0;
            if (state == FLUSH && flush_cnt != '0) flush_cnt <= flush_cnt - CW'(1);
            if (grant) begin
                base      <= pick_d ? i_d_address : i_if_address;
                wr        <= pick_d & i_d_write;
                wdata     <= pick_d ? i_d_wdata : '0;
                last_k    <= grant_last_k;
                k         <= '0;
                result    <= '0;
                grant_d   <= pick_d;
                last_data <= pick_d;
                if (trap_hit) begin
                    o_d_ack   <= 1'b1;
                    o_d_rdata <= '0;
                end
            end
            if (state == ACCESS && i_mem_data_DV) begin
                result <= result_cap;
                k      <= k + 2'd1;
                if (done) begin
                    if (grant_d) begin
                        o_d_ack   <= 1'b1;
                        o_d_rdata <= result_cap;
                    end else begin
                        o_if_ack  <= 1'b1;
                        o_if_data <= result_cap;
                    end
                end
            end
        end
    end

`ifdef MEM_SEQ_MISALIGN_TRAP_EN
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) o_d_misalign <= 1'b0;
        else         o_d_misalign <= trap_hit;
    end
`else
    assign o_d_misalign = 1'b0;
`endif

endmodule
